// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: measures high pulses on an asynchronous servo PWM line,
// classifies them as 1.0 / 1.5 / 2.0 ms positions and detects loss of signal.
module servo_pwm_decoder #(
    parameter int unsigned CLKS_PER_MS  = 27000,
    parameter int unsigned TOL_CLKS     = 2700,
    parameter int unsigned MIN_CLKS     = 13500,
    parameter int unsigned MAX_CLKS     = 67500,
    parameter int unsigned TIMEOUT_CLKS = 675000,
    parameter int unsigned CNT_W        = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] width_cycles,
    output logic [1:0]       pos_code,
    output logic             width_valid,
    output logic             width_err,
    output logic             signal_lost
);

    localparam int unsigned EXT_W = CNT_W + 1;

    // Nominal widths for k = 2, 3, 4 half-milliseconds
    localparam int NOM0 = int'(CLKS_PER_MS);
    localparam int NOM1 = int'((3 * CLKS_PER_MS) / 2);
    localparam int NOM2 = int'(2 * CLKS_PER_MS);
    localparam int TOL  = int'(TOL_CLKS);

    // Classification windows, signed so a tolerance wider than a nominal stays safe
    localparam logic signed [EXT_W-1:0] LO0 = EXT_W'(NOM0 - TOL);
    localparam logic signed [EXT_W-1:0] HI0 = EXT_W'(NOM0 + TOL);
    localparam logic signed [EXT_W-1:0] LO1 = EXT_W'(NOM1 - TOL);
    localparam logic signed [EXT_W-1:0] HI1 = EXT_W'(NOM1 + TOL);
    localparam logic signed [EXT_W-1:0] LO2 = EXT_W'(NOM2 - TOL);
    localparam logic signed [EXT_W-1:0] HI2 = EXT_W'(NOM2 + TOL);

    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_CLKS);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_CLKS);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CLKS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [1:0]       fill_q, fill_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [1:0]       pos_q, pos_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             lost_q, lost_d;

    logic                    sync_ok_c;
    logic                    rise_c;
    logic                    fall_c;
    logic                    timeout_c;
    logic                    legal_c;
    logic signed [EXT_W-1:0] hi_ext_c;
    logic [1:0]              code_c;

    assign width_cycles = width_q;
    assign pos_code     = pos_q;
    assign width_valid  = valid_q;
    assign width_err    = err_q;
    assign signal_lost  = lost_q;

    // Edge decode; suppressed until the history flop holds a real sample after reset
    assign sync_ok_c = (fill_q == 2'd3);
    assign rise_c    = sync_ok_c & s2_q & ~s3_q;
    assign fall_c    = sync_ok_c & ~s2_q & s3_q;
    assign timeout_c = (to_cnt_q == TIMEOUT_C);

    // Pulse legality and position classification from the measured count
    always_comb begin
        hi_ext_c = signed'({1'b0, hi_cnt_q});
        legal_c  = (hi_cnt_q >= MIN_C) && (hi_cnt_q <= MAX_C);
        code_c   = 2'd3;
        if ((hi_ext_c >= LO0) && (hi_ext_c <= HI0)) begin
            code_c = 2'd0;
        end else if ((hi_ext_c >= LO1) && (hi_ext_c <= HI1)) begin
            code_c = 2'd1;
        end else if ((hi_ext_c >= LO2) && (hi_ext_c <= HI2)) begin
            code_c = 2'd2;
        end
    end

    // Next-state: synchronizer, counters, FSM and output strobes
    always_comb begin
        s1_d     = pwm_in;
        s2_d     = s1_q;
        s3_d     = s2_q;
        fill_d   = sync_ok_c ? fill_q : fill_q + 2'd1;
        state_d  = state_q;
        hi_cnt_d = hi_cnt_q;
        to_cnt_d = to_cnt_q;
        width_d  = width_q;
        pos_d    = pos_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        lost_d   = lost_q;

        if (rise_c) begin
            to_cnt_d = '0;
        end else if (!timeout_c) begin
            to_cnt_d = to_cnt_q + CNT_ONE;
        end

        if (timeout_c && !rise_c) begin
            lost_d  = 1'b1;
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rise_c) begin
                        state_d  = ST_HIGH;
                        hi_cnt_d = CNT_ONE;
                        lost_d   = 1'b0;
                    end
                end
                ST_HIGH: begin
                    if (fall_c) begin
                        state_d = ST_LOW;
                        if (legal_c) begin
                            width_d = hi_cnt_q;
                            pos_d   = code_c;
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (hi_cnt_q != '1) begin
                        hi_cnt_d = hi_cnt_q + CNT_ONE;
                    end
                end
                ST_LOW: begin
                    if (rise_c) begin
                        state_d  = ST_HIGH;
                        hi_cnt_d = CNT_ONE;
                        lost_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            fill_q   <= 2'd0;
            hi_cnt_q <= '0;
            to_cnt_q <= '0;
            width_q  <= '0;
            pos_q    <= 2'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            fill_q   <= fill_d;
            hi_cnt_q <= hi_cnt_d;
            to_cnt_q <= to_cnt_d;
            width_q  <= width_d;
            pos_q    <= pos_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            lost_q   <= lost_d;
        end
    end

endmodule
